// File: rtl/spiral_pkg.sv
// Shared constants and sideband types for the spiral radius pipeline.
package spiral_pkg;

  localparam int   COORD_W   = 10;
  localparam int   LAT       = COORD_W + 2;
  localparam int   SQ_W      = 2 * COORD_W;
  localparam int   REM_W     = SQ_W + 2;
  localparam logic SYNC_IDLE = 1'b1;

  // Per-pixel tags that ride alongside the arithmetic.
  typedef struct packed {
    logic valid;
    logic hsync;
    logic vsync;
    logic de;
  } side_t;

  // Value a sideband stage holds after reset: no pixel, syncs idle.
  function automatic side_t side_reset(input logic sync_idle);
    side_t s;
    s.valid = 1'b0;
    s.hsync = sync_idle;
    s.vsync = sync_idle;
    s.de    = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/radius_isqrt_pipe_isqrt_step.sv
// One non-restoring square-root iteration: consumes two radicand bits and
// resolves one root bit (MSB first). Purely combinational.
module isqrt_step #(
  parameter int ROOT_W = 10,
  parameter int REM_W  = 22
) (
  input  logic signed [REM_W-1:0]  rem_in,
  input  logic        [ROOT_W-1:0] root_in,
  input  logic        [1:0]        bits_in,
  output logic signed [REM_W-1:0]  rem_out,
  output logic        [ROOT_W-1:0] root_out
);

  logic                    rem_neg;
  logic signed [REM_W-1:0] rem_shifted;
  logic signed [REM_W-1:0] trial;

  // A negative remainder adds (4q+3), a non-negative one subtracts (4q+1);
  // the sign of the new remainder is the next root bit.
  always_comb begin
    rem_neg          = rem_in[REM_W-1];
    rem_shifted      = rem_in <<< 2;
    rem_shifted[1:0] = bits_in;
    trial            = {{(REM_W-ROOT_W-2){1'b0}}, root_in, rem_neg, 1'b1};
    rem_out          = rem_neg ? (rem_shifted + trial) : (rem_shifted - trial);
    root_out         = {root_in[ROOT_W-2:0], ~rem_out[REM_W-1]};
  end

endmodule

// File: rtl/radius_isqrt_pipe.sv
// Fully pipelined floor(sqrt(x^2+y^2)) with ring index and sync sideband
// delayed by exactly the arithmetic latency (COORD_W+2 advancing cycles).
module radius_isqrt_pipe #(
  parameter int   COORD_W    = spiral_pkg::COORD_W,
  parameter int   RING_SHIFT = 3,
  parameter int   RING_W     = 5,
  parameter logic SYNC_IDLE  = spiral_pkg::SYNC_IDLE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ce,
  input  logic                      in_valid,
  input  logic signed [COORD_W-1:0] x_in,
  input  logic signed [COORD_W-1:0] y_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      de_in,
  output logic        [COORD_W-1:0] root_out,
  output logic        [RING_W-1:0]  ring_out,
  output logic                      valid_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      de_out
);

  import spiral_pkg::*;

  localparam int PIPE_LAT = COORD_W + 2;
  localparam int SUM_W    = 2 * COORD_W;
  localparam int RES_W    = SUM_W + 2;

  // Stage 1: magnitudes. Stage 2: sum of squares.
  logic [COORD_W-1:0] abs_x_next, abs_y_next;
  logic [COORD_W-1:0] abs_x_reg, abs_y_reg;
  logic [SUM_W-1:0]   abs_x_wide, abs_y_wide, sum_next;
  logic [SUM_W-1:0]   sum_reg;

  // Root stages: element i is the register after the i-th iteration.
  logic signed [RES_W-1:0]   rem_reg  [1:COORD_W];
  logic        [COORD_W-1:0] root_reg [1:COORD_W];
  logic        [SUM_W-1:0]   rad_reg  [1:COORD_W-1];

  // Inputs and outputs of each iteration.
  logic signed [RES_W-1:0]   rem_cur   [0:COORD_W-1];
  logic        [COORD_W-1:0] root_cur  [0:COORD_W-1];
  logic        [SUM_W-1:0]   rad_cur   [0:COORD_W-1];
  logic signed [RES_W-1:0]   rem_next  [0:COORD_W-1];
  logic        [COORD_W-1:0] root_next [0:COORD_W-1];
  logic        [SUM_W-1:0]   rad_next  [0:COORD_W-2];

  side_t side_in;
  side_t side_reg [1:PIPE_LAT];

  // Two's-complement magnitude; the most negative code maps to 2^(COORD_W-1)
  // which still fits the unsigned width.
  always_comb begin
    abs_x_next = x_in[COORD_W-1] ? (~x_in + 1'b1) : x_in;
    abs_y_next = y_in[COORD_W-1] ? (~y_in + 1'b1) : y_in;
    abs_x_wide = SUM_W'(abs_x_reg);
    abs_y_wide = SUM_W'(abs_y_reg);
    sum_next   = abs_x_wide * abs_x_wide + abs_y_wide * abs_y_wide;
    side_in.valid = in_valid;
    side_in.hsync = hsync_in;
    side_in.vsync = vsync_in;
    side_in.de    = de_in;
  end

  genvar gi;
  generate
    for (gi = 0; gi < COORD_W; gi++) begin : g_step
      if (gi == 0) begin : g_first
        assign rem_cur[gi]  = '0;
        assign root_cur[gi] = '0;
        assign rad_cur[gi]  = sum_reg;
      end else begin : g_rest
        assign rem_cur[gi]  = rem_reg[gi];
        assign root_cur[gi] = root_reg[gi];
        assign rad_cur[gi]  = rad_reg[gi];
      end

      isqrt_step #(
        .ROOT_W (COORD_W),
        .REM_W  (RES_W)
      ) u_step (
        .rem_in   (rem_cur[gi]),
        .root_in  (root_cur[gi]),
        .bits_in  (rad_cur[gi][SUM_W-1 -: 2]),
        .rem_out  (rem_next[gi]),
        .root_out (root_next[gi])
      );

      // The radicand is shifted so the next pair is always at the top.
      if (gi < COORD_W - 1) begin : g_rad
        assign rad_next[gi] = rad_cur[gi] << 2;
      end
    end
  endgenerate

  // Arithmetic pipeline registers; all hold when ce is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abs_x_reg <= '0;
      abs_y_reg <= '0;
      sum_reg   <= '0;
      for (int i = 1; i <= COORD_W; i++) begin
        rem_reg[i]  <= '0;
        root_reg[i] <= '0;
      end
      for (int i = 1; i < COORD_W; i++) begin
        rad_reg[i] <= '0;
      end
    end else if (ce) begin
      abs_x_reg <= abs_x_next;
      abs_y_reg <= abs_y_next;
      sum_reg   <= sum_next;
      for (int i = 1; i <= COORD_W; i++) begin
        rem_reg[i]  <= rem_next[i-1];
        root_reg[i] <= root_next[i-1];
      end
      for (int i = 1; i < COORD_W; i++) begin
        rad_reg[i] <= rad_next[i-1];
      end
    end
  end

  // Sideband shift register matching the arithmetic depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= PIPE_LAT; i++) begin
        side_reg[i] <= side_reset(SYNC_IDLE);
      end
    end else if (ce) begin
      side_reg[1] <= side_in;
      for (int i = 2; i <= PIPE_LAT; i++) begin
        side_reg[i] <= side_reg[i-1];
      end
    end
  end

  assign root_out  = root_reg[COORD_W];
  assign ring_out  = RING_W'(root_reg[COORD_W] >> RING_SHIFT);
  assign valid_out = side_reg[PIPE_LAT].valid;
  assign hsync_out = side_reg[PIPE_LAT].hsync;
  assign vsync_out = side_reg[PIPE_LAT].vsync;
  assign de_out    = side_reg[PIPE_LAT].de;

endmodule

// File: tb/tb_radius_isqrt_pipe.sv
// Directed bench for radius_isqrt_pipe: latency, exact roots, extremes,
// sync alignment over a small frame, ce stalls and asynchronous reset.
module tb_radius_isqrt_pipe;

  localparam int LAT = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ce = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [9:0] x_in = '0;
  logic signed [9:0] y_in = '0;
  logic              hsync_in = 1'b1;
  logic              vsync_in = 1'b1;
  logic              de_in = 1'b0;
  logic [9:0]        root_out;
  logic [4:0]        ring_out;
  logic              valid_out, hsync_out, vsync_out, de_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  radius_isqrt_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .in_valid  (in_valid),
    .x_in      (x_in),
    .y_in      (y_in),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .de_in     (de_in),
    .root_out  (root_out),
    .ring_out  (ring_out),
    .valid_out (valid_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .de_out    (de_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int x, input int y,
                       input logic hs, input logic vs, input logic d);
    in_valid = v;
    x_in     = 10'(x);
    y_in     = 10'(y);
    hsync_in = hs;
    vsync_in = vs;
    de_in    = d;
  endtask

  task automatic apply_reset();
    ce = 1'b1;
    drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int isqrt_ref(input int s);
    int r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  task automatic test_reset();
    ce = 1'b1;
    rst_n = 1'b0;
    drive(1'b1, 3, 4, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 3; n++) begin
      tick();
      tests++;
      if ({valid_out, de_out} !== 2'b00) begin
        fails++;
        $display("FAIL reset_valid_de: got %b expected 00", {valid_out, de_out});
      end
      tests++;
      if ({hsync_out, vsync_out} !== 2'b11) begin
        fails++;
        $display("FAIL reset_sync: got %b expected 11", {hsync_out, vsync_out});
      end
      tests++;
      if (root_out !== 10'd0 || ring_out !== 5'd0) begin
        fails++;
        $display("FAIL reset_root: got root=%0d ring=%0d expected 0 0", root_out, ring_out);
      end
    end
    rst_n = 1'b1;
    $display("[TB] reset values checked");
  endtask

  task automatic test_impulse();
    apply_reset();
    for (int n = 1; n <= 20; n++) begin
      if (n == 1) drive(1'b1, 3, 4, 1'b1, 1'b1, 1'b1);
      else        drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      tick();
      tests++;
      if (valid_out !== (n == LAT)) begin
        fails++;
        $display("FAIL impulse_valid cycle %0d: got %b expected %b", n, valid_out, (n == LAT));
      end
      if (n == LAT) begin
        tests++;
        if (root_out !== 10'd5 || ring_out !== 5'd0) begin
          fails++;
          $display("FAIL impulse_root: got root=%0d ring=%0d expected 5 0", root_out, ring_out);
        end
        $display("[TB] impulse x=3 y=4 -> root=%0d ring=%0d at cycle %0d", root_out, ring_out, n);
      end
    end
  endtask

  task automatic test_back_to_back();
    int vx [11];
    int vy [11];
    int er [11];
    int eg [11];
    int idx;
    vx = '{24, 0, -5, 10, -512, 511, 3, 15, 16,  0, 8};
    vy = '{-7, 0, 12, 10, -512,   0, 4,  0,  0, -1, 8};
    er = '{25, 0, 13, 14,  724, 511, 5, 15, 16,  1, 11};
    eg = '{ 3, 0,  1,  1,   26,  31, 0,  1,  2,  0, 1};
    apply_reset();
    for (int n = 0; n < 11 + LAT - 1; n++) begin
      if (n < 11) drive(1'b1, vx[n], vy[n], 1'b1, 1'b1, 1'b1);
      else        drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      tick();
      if (n >= LAT - 1) begin
        idx = n - (LAT - 1);
        tests++;
        if (valid_out !== 1'b1 || root_out !== 10'(er[idx]) || ring_out !== 5'(eg[idx])) begin
          fails++;
          $display("FAIL exact x=%0d y=%0d: got valid=%b root=%0d ring=%0d expected 1 %0d %0d",
                   vx[idx], vy[idx], valid_out, root_out, ring_out, er[idx], eg[idx]);
        end
        $display("[TB] exact x=%0d y=%0d -> root=%0d ring=%0d", vx[idx], vy[idx], root_out, ring_out);
      end
    end
  endtask

  task automatic test_sync_alignment();
    localparam int HT = 24;
    localparam int VT = 12;
    localparam int FRAME = HT * VT;
    logic hs_h [FRAME + LAT];
    logic vs_h [FRAME + LAT];
    logic de_h [FRAME + LAT];
    int   rt_h [FRAME + LAT];
    int   h, v, x, y, k;
    int   bad = 0;
    logic hs, vs, d;
    apply_reset();
    for (int n = 0; n < FRAME + LAT - 1; n++) begin
      if (n < FRAME) begin
        h  = n % HT;
        v  = n / HT;
        hs = !(h >= 18 && h < 20);
        vs = (v != 10);
        d  = (h < 16) && (v < 9);
        x  = h - 8;
        y  = v - 4;
      end else begin
        hs = 1'b1; vs = 1'b1; d = 1'b0; x = 0; y = 0;
      end
      hs_h[n] = hs;
      vs_h[n] = vs;
      de_h[n] = d;
      rt_h[n] = isqrt_ref(x * x + y * y);
      drive(d, x, y, hs, vs, d);
      tick();
      tests++;
      if (n < LAT - 1) begin
        if ({valid_out, hsync_out, vsync_out, de_out} !== 4'b0110 || root_out !== 10'd0) begin
          fails++; bad++;
          $display("FAIL sync_prefill cycle %0d: got vhvd=%b root=%0d expected 0110 0",
                   n, {valid_out, hsync_out, vsync_out, de_out}, root_out);
        end
      end else begin
        k = n - (LAT - 1);
        if ({hsync_out, vsync_out, de_out, valid_out} !== {hs_h[k], vs_h[k], de_h[k], de_h[k]}) begin
          fails++; bad++;
          $display("FAIL sync_align cycle %0d: got hvdv=%b expected %b", n,
                   {hsync_out, vsync_out, de_out, valid_out}, {hs_h[k], vs_h[k], de_h[k], de_h[k]});
        end
        tests++;
        if (root_out !== 10'(rt_h[k]) || ring_out !== 5'((rt_h[k] >> 3) & 31)) begin
          fails++; bad++;
          $display("FAIL sync_root cycle %0d: got root=%0d ring=%0d expected %0d %0d", n,
                   root_out, ring_out, rt_h[k], (rt_h[k] >> 3) & 31);
        end
      end
    end
    $display("[TB] frame %0dx%0d streamed, %0d mismatching cycles", HT, VT, bad);
  endtask

  task automatic test_ce_stall();
    logic [9:0] snap_root;
    logic [4:0] snap_ring;
    logic [3:0] snap_side;
    apply_reset();
    // Prefill with varying roots so held outputs are distinguishable.
    for (int k = 0; k < LAT; k++) begin
      drive(1'b0, 20 + k, 0, 1'b1, 1'b1, 1'(k & 1));
      tick();
    end
    snap_root = '0; snap_ring = '0; snap_side = '0;
    for (int n = 1; n <= 20; n++) begin
      ce = !(n >= 6 && n <= 8);
      if (n == 1) drive(1'b1, 3, 4, 1'b1, 1'b1, 1'b1);
      else        drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      tick();
      if (n == 5) begin
        snap_root = root_out;
        snap_ring = ring_out;
        snap_side = {valid_out, hsync_out, vsync_out, de_out};
      end
      if (n >= 6 && n <= 8) begin
        tests++;
        if (root_out !== snap_root || ring_out !== snap_ring ||
            {valid_out, hsync_out, vsync_out, de_out} !== snap_side) begin
          fails++;
          $display("FAIL stall_hold cycle %0d: got root=%0d ring=%0d side=%b expected %0d %0d %b",
                   n, root_out, ring_out, {valid_out, hsync_out, vsync_out, de_out},
                   snap_root, snap_ring, snap_side);
        end
      end
      tests++;
      if (valid_out !== (n == 15)) begin
        fails++;
        $display("FAIL stall_valid cycle %0d: got %b expected %b", n, valid_out, (n == 15));
      end
      if (n == 15) begin
        tests++;
        if (root_out !== 10'd5 || ring_out !== 5'd0) begin
          fails++;
          $display("FAIL stall_root: got root=%0d ring=%0d expected 5 0", root_out, ring_out);
        end
        $display("[TB] stalled x=3 y=4 -> root=%0d at wall cycle %0d", root_out, n);
      end
    end
    ce = 1'b1;
    // Confirm a held stage actually had data (root 25 from the prefill).
    tests++;
    if (snap_root !== 10'd25) begin
      fails++;
      $display("FAIL stall_snapshot: got root=%0d expected 25", snap_root);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int k = 0; k < LAT; k++) begin
      drive(1'b1, 9, 0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 3 + k, 4, 1'b0, 1'b0, 1'b1);
      tick();
    end
    tests++;
    if ({valid_out, hsync_out, vsync_out, de_out} !== 4'b1001 || root_out !== 10'd9) begin
      fails++;
      $display("FAIL areset_pre: got side=%b root=%0d expected 1001 9",
               {valid_out, hsync_out, vsync_out, de_out}, root_out);
    end
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({valid_out, hsync_out, vsync_out, de_out} !== 4'b0110 ||
        root_out !== 10'd0 || ring_out !== 5'd0) begin
      fails++;
      $display("FAIL areset_immediate: got side=%b root=%0d ring=%0d expected 0110 0 0",
               {valid_out, hsync_out, vsync_out, de_out}, root_out, ring_out);
    end
    drive(1'b1, 7, 7, 1'b0, 1'b0, 1'b1);
    tick();
    tests++;
    if ({valid_out, hsync_out, vsync_out, de_out} !== 4'b0110 || root_out !== 10'd0) begin
      fails++;
      $display("FAIL areset_held: got side=%b root=%0d expected 0110 0",
               {valid_out, hsync_out, vsync_out, de_out}, root_out);
    end
    #3;
    rst_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      if (n == 1) drive(1'b1, 6, 8, 1'b1, 1'b1, 1'b1);
      else        drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      tick();
      tests++;
      if (valid_out !== (n == LAT) || root_out !== ((n == LAT) ? 10'd10 : 10'd0) ||
          ring_out !== ((n == LAT) ? 5'd1 : 5'd0)) begin
        fails++;
        $display("FAIL areset_after cycle %0d: got valid=%b root=%0d ring=%0d expected %b %0d %0d",
                 n, valid_out, root_out, ring_out, (n == LAT), (n == LAT) ? 10 : 0, (n == LAT) ? 1 : 0);
      end
    end
    $display("[TB] async reset flushed in-flight samples");
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_back_to_back();
    test_sync_alignment();
    test_ce_stall();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
